// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared FU/CDB types and sizing for the CDB arbiter slice.
`ifndef N
`define N 2
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 2
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 2
`endif
`ifndef NUM_FU_BRANCH
`define NUM_FU_BRANCH 1
`endif
`ifndef NUM_FU_MEM
`define NUM_FU_MEM 1
`endif

package cdb_arbiter_pkg;
    localparam int NUM_FU_ALU = `NUM_FU_ALU;
    localparam int NUM_FU_MULT = `NUM_FU_MULT;
    localparam int NUM_FU_BRANCH = `NUM_FU_BRANCH;
    localparam int NUM_FU_MEM = `NUM_FU_MEM;
    localparam int R = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_BRANCH + NUM_FU_MEM;
    localparam int PTR_W = $clog2(R);

    typedef logic [5:0] PHYS_TAG;
    typedef logic [31:0] DATA;

    // MEM is declared first so ALU lands in the low bits when flattened.
    typedef struct packed {
        logic [NUM_FU_MEM-1:0] mem;
        logic [NUM_FU_BRANCH-1:0] branch;
        logic [NUM_FU_MULT-1:0] mult;
        logic [NUM_FU_ALU-1:0] alu;
    } FU_REQUESTS;

    typedef FU_REQUESTS FU_GRANTS;

    typedef struct packed {
        PHYS_TAG tag;
        DATA data;
    } FU_RESULT;

    typedef struct packed {
        FU_RESULT [NUM_FU_MEM-1:0] mem;
        FU_RESULT [NUM_FU_BRANCH-1:0] branch;
        FU_RESULT [NUM_FU_MULT-1:0] mult;
        FU_RESULT [NUM_FU_ALU-1:0] alu;
    } FU_RESULTS;

    typedef struct packed {
        logic valid;
        PHYS_TAG tag;
        DATA data;
    } CDB_PACKET;
endpackage

// File: rtl/cdb_rr_picker.sv
// cdb_rr_picker: circular scan from ptr_i, first S set request bits become ordered one-hot grants.
module cdb_rr_picker #(
    parameter int R = 6,
    parameter int S = 2,
    parameter int PW = $clog2(R)
) (
    input logic [R-1:0] req_i,
    input logic [PW-1:0] ptr_i,
    output logic [S-1:0][R-1:0] gnt_o
);
    int idx;
    int cnt;

    always_comb begin
        gnt_o = '0;
        cnt = 0;
        idx = 0;
        for (int i = 0; i < R; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= R) idx = idx - R;
            if (req_i[idx] && cnt < S) begin
                gnt_o[cnt][idx] = 1'b1;
                cnt = cnt + 1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB slot arbiter with combinational grants and registered broadcast.
// CDB_STARVE_GUARD_EN adds per-requester starvation counters that force slot 0.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_CDB = `N,
    parameter int STARVE_LIMIT = 4
) (
    input logic clock,
    input logic reset,
    input logic mispredict,
    input FU_REQUESTS cdb_requests,
    input logic [`NUM_FU_MULT-1:0] mult_requests,
    input FU_RESULTS fu_results,
    output FU_GRANTS fu_grants,
    output CDB_PACKET [NUM_CDB-1:0] cdb_out,
    output logic [PTR_W-1:0] rr_ptr_dbg
);
    logic [R-1:0] req, req_eff, pick_req, g_flat;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_CDB-1:0][R-1:0] pick, slot;
    CDB_PACKET [NUM_CDB-1:0] cdb_d, cdb_q;
    FU_RESULT [R-1:0] res;

    assign req = {cdb_requests.mem, cdb_requests.branch, cdb_requests.mult | mult_requests, cdb_requests.alu};
    assign req_eff = (reset || mispredict) ? '0 : req;
    assign res = fu_results;

    cdb_rr_picker #(.R(R), .S(NUM_CDB), .PW(PTR_W)) u_picker (
        .req_i(pick_req),
        .ptr_i(rr_ptr_q),
        .gnt_o(pick)
    );

`ifdef CDB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] cnt_q [R];
    logic [R-1:0] starving, frc;

    always_comb begin
        starving = '0;
        for (int i = 0; i < R; i++) starving[i] = req_eff[i] && (cnt_q[i] == CW'(STARVE_LIMIT));
    end

    // Lowest-index starving requester wins slot 0; the scan fills the rest.
    assign frc = starving & (~starving + R'(1));
    assign pick_req = req_eff & ~frc;

    always_comb begin
        slot = pick;
        if (|frc) begin
            slot[0] = frc;
            for (int k = 1; k < NUM_CDB; k++) slot[k] = pick[k-1];
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < R; i++) begin
            if (reset) cnt_q[i] <= '0;
            else if (req[i] && !g_flat[i]) cnt_q[i] <= (cnt_q[i] == CW'(STARVE_LIMIT)) ? cnt_q[i] : cnt_q[i] + CW'(1);
            else cnt_q[i] <= '0;
        end
    end
`else
    assign pick_req = req_eff;
    assign slot = pick;
`endif

    always_comb begin
        g_flat = '0;
        for (int k = 0; k < NUM_CDB; k++) g_flat = g_flat | slot[k];
    end

    assign fu_grants = g_flat;

    // Later slots overwrite rr_ptr_d, so it ends up just past the last granted requester.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        cdb_d = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            for (int i = 0; i < R; i++) begin
                if (slot[k][i]) begin
                    rr_ptr_d = (i == R - 1) ? '0 : PTR_W'(i + 1);
                    cdb_d[k] = '{valid: 1'b1, tag: res[i].tag, data: res[i].data};
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || mispredict) begin
            rr_ptr_q <= '0;
            cdb_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q <= cdb_d;
        end
    end

    assign cdb_out = cdb_q;
    assign rr_ptr_dbg = rr_ptr_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of grants, broadcast, pointer, flush and reset behaviour.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NC = 2;

    logic clock = 1'b0;
    logic reset, mispredict;
    FU_REQUESTS cdb_requests;
    logic [NUM_FU_MULT-1:0] mult_requests;
    FU_RESULTS fu_results;
    FU_GRANTS fu_grants;
    CDB_PACKET [NC-1:0] cdb_out;
    logic [PTR_W-1:0] rr_ptr_dbg;
    logic [R-1:0] g, seen;
    FU_RESULT [R-1:0] ra;
    int passed = 0;
    int total = 0;

    cdb_arbiter #(.NUM_CDB(NC), .STARVE_LIMIT(4)) dut (
        .clock(clock),
        .reset(reset),
        .mispredict(mispredict),
        .cdb_requests(cdb_requests),
        .mult_requests(mult_requests),
        .fu_results(fu_results),
        .fu_grants(fu_grants),
        .cdb_out(cdb_out),
        .rr_ptr_dbg(rr_ptr_dbg)
    );

    always #5 clock = ~clock;
    assign g = fu_grants;

    function automatic CDB_PACKET pkt(input int i);
        return '{valid: 1'b1, tag: PHYS_TAG'(10 + i), data: 32'hD000_0000 + DATA'(i)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Drive one cycle, check grants mid-cycle, then land just after the clock edge.
    task automatic step(input logic [R-1:0] r, input logic [NUM_FU_MULT-1:0] m, input logic mp,
                        input logic rst, input logic [R-1:0] eg, input string nm);
        cdb_requests = r;
        mult_requests = m;
        mispredict = mp;
        reset = rst;
        @(negedge clock);
        seen = seen | g;
        chk({nm, "_grant"}, 64'(g), 64'(eg));
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < R; i++) ra[i] = '{tag: PHYS_TAG'(10 + i), data: 32'hD000_0000 + DATA'(i)};
        fu_results = ra;
        seen = '0;
        step(6'h3f, 2'b11, 1'b0, 1'b1, 6'h00, "reset");
        chk("reset_ptr", 64'(rr_ptr_dbg), 64'd0);
        chk("reset_c0", 64'(cdb_out[0]), 64'd0);
        chk("reset_c1", 64'(cdb_out[1]), 64'd0);

        step(6'b010011, 2'b00, 1'b0, 1'b0, 6'b000011, "basic");
        chk("basic_c0", 64'(cdb_out[0]), 64'(pkt(0)));
        chk("basic_c1", 64'(cdb_out[1]), 64'(pkt(1)));
        chk("basic_ptr", 64'(rr_ptr_dbg), 64'd2);

        step(6'b010011, 2'b00, 1'b0, 1'b0, 6'b010001, "circ");
        chk("circ_c0", 64'(cdb_out[0]), 64'(pkt(4)));
        chk("circ_c1", 64'(cdb_out[1]), 64'(pkt(0)));
        chk("circ_ptr", 64'(rr_ptr_dbg), 64'd1);

        step(6'b000000, 2'b01, 1'b0, 1'b0, 6'b000100, "mult");
        chk("mult_c0", 64'(cdb_out[0]), 64'(pkt(2)));
        chk("mult_c1v", 64'(cdb_out[1].valid), 64'd0);
        chk("mult_ptr", 64'(rr_ptr_dbg), 64'd3);

        seen = '0;
        step(6'h3f, 2'b00, 1'b0, 1'b0, 6'b011000, "all_a");
        chk("all_a_ptr", 64'(rr_ptr_dbg), 64'd5);
        step(6'h3f, 2'b00, 1'b0, 1'b0, 6'b100001, "all_b");
        chk("all_b_c0", 64'(cdb_out[0]), 64'(pkt(5)));
        chk("all_b_c1", 64'(cdb_out[1]), 64'(pkt(0)));
        chk("all_b_ptr", 64'(rr_ptr_dbg), 64'd1);
        step(6'h3f, 2'b00, 1'b0, 1'b0, 6'b000110, "all_c");
        chk("all_c_ptr", 64'(rr_ptr_dbg), 64'd3);
        chk("all_seen", 64'(seen), 64'h3f);

        step(6'b100000, 2'b00, 1'b0, 1'b0, 6'b100000, "wrap");
        chk("wrap_c0", 64'(cdb_out[0]), 64'(pkt(5)));
        chk("wrap_c1v", 64'(cdb_out[1].valid), 64'd0);
        chk("wrap_ptr", 64'(rr_ptr_dbg), 64'd0);

        step(6'b100010, 2'b00, 1'b0, 1'b0, 6'b100010, "fit");
        chk("fit_c0", 64'(cdb_out[0]), 64'(pkt(1)));
        chk("fit_c1", 64'(cdb_out[1]), 64'(pkt(5)));
        chk("fit_ptr", 64'(rr_ptr_dbg), 64'd0);

        step(6'b001000, 2'b01, 1'b0, 1'b0, 6'b001100, "mult_or");
        chk("mult_or_c0", 64'(cdb_out[0]), 64'(pkt(2)));
        chk("mult_or_c1", 64'(cdb_out[1]), 64'(pkt(3)));
        chk("mult_or_ptr", 64'(rr_ptr_dbg), 64'd4);

        step(6'b010011, 2'b00, 1'b0, 1'b0, 6'b010001, "pre_flush");
        chk("pre_flush_ptr", 64'(rr_ptr_dbg), 64'd1);
        step(6'b010011, 2'b00, 1'b1, 1'b0, 6'b000000, "flush");
        chk("flush_c0v", 64'(cdb_out[0].valid), 64'd0);
        chk("flush_c1v", 64'(cdb_out[1].valid), 64'd0);
        chk("flush_ptr", 64'(rr_ptr_dbg), 64'd0);

        step(6'b000011, 2'b00, 1'b0, 1'b0, 6'b000011, "pre_rst");
        chk("pre_rst_c0", 64'(cdb_out[0]), 64'(pkt(0)));
        chk("pre_rst_ptr", 64'(rr_ptr_dbg), 64'd2);
        step(6'b000011, 2'b00, 1'b1, 1'b1, 6'b000000, "mid_rst");
        chk("mid_rst_c0", 64'(cdb_out[0]), 64'd0);
        chk("mid_rst_c1", 64'(cdb_out[1]), 64'd0);
        chk("mid_rst_ptr", 64'(rr_ptr_dbg), 64'd0);

`ifdef CDB_STARVE_GUARD_EN
        step(6'b100011, 2'b00, 1'b0, 1'b0, 6'b000011, "stv1");
        step(6'b101100, 2'b00, 1'b0, 1'b0, 6'b001100, "stv2");
        step(6'b100000, 2'b00, 1'b1, 1'b0, 6'b000000, "stv3");
        step(6'b100011, 2'b00, 1'b0, 1'b0, 6'b000011, "stv4");
        step(6'b101100, 2'b00, 1'b0, 1'b0, 6'b100100, "stv5");
        chk("stv5_c0", 64'(cdb_out[0]), 64'(pkt(5)));
        chk("stv5_c1", 64'(cdb_out[1]), 64'(pkt(2)));
        chk("stv5_ptr", 64'(rr_ptr_dbg), 64'd3);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
